// File: rtl/uart_tx_fifo_if.sv
// Host/controller-facing signal bundle for the UART TX show-ahead FIFO.
// P_DATA/DATA_VALID show the head word; a TX_START cycle with DATA_VALID high pops it at that edge.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  logic [DATA_WIDTH-1:0]  WR_DATA;
  logic                   WR_EN;
  logic                   TX_START;
  logic                   CLR_OVF;
  logic [DATA_WIDTH-1:0]  P_DATA;
  logic                   DATA_VALID;
  logic                   FULL;
  logic                   ALMOST_FULL;
  logic [$clog2(DEPTH):0] COUNT;
  logic                   OVERFLOW;

  modport master (
    output WR_DATA, WR_EN, TX_START, CLR_OVF,
    input  P_DATA, DATA_VALID, FULL, ALMOST_FULL, COUNT, OVERFLOW
  );

  modport slave (
    input  WR_DATA, WR_EN, TX_START, CLR_OVF,
    output P_DATA, DATA_VALID, FULL, ALMOST_FULL, COUNT, OVERFLOW
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding the UART TX frame controller; pops once per TX_START cycle.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  valid_q;
  logic                  full_q;
  logic                  af_q;
  logic                  ovf_q;
  logic                  pop;
  logic                  wa;
  logic                  ovf_set;

  // A write into a full FIFO is still accepted when the head leaves the same cycle.
  assign pop     = bus.TX_START & valid_q;
  assign wa      = bus.WR_EN & (~full_q | pop);
  assign ovf_set = bus.WR_EN & full_q & ~pop;

  always_comb begin
    count_nxt = count_q;
    if (wa && !pop)
      count_nxt = count_q + 1'b1;
    else if (pop && !wa)
      count_nxt = count_q - 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (wa)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_nxt;
      valid_q <= (count_nxt != '0);
      full_q  <= (count_nxt == DEPTH_C);
      af_q    <= (count_nxt >= AF_C);
      if (ovf_set)
        ovf_q <= 1'b1;
      else if (bus.CLR_OVF)
        ovf_q <= 1'b0;
    end
  end

  // Storage carries no reset; stale entries are never visible while DATA_VALID is low.
  always_ff @(posedge CLK) begin
    if (wa)
      mem[wr_ptr] <= bus.WR_DATA;
  end

  assign bus.P_DATA      = mem[rd_ptr];
  assign bus.DATA_VALID  = valid_q;
  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = af_q;
  assign bus.COUNT       = count_q;
  assign bus.OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: randomized traffic against a queue-based reference of the FIFO.
module tb_uart_tx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  logic [DW-1:0] model_q[$];
  logic          model_ovf;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {DATA_VALID, FULL, ALMOST_FULL, OVERFLOW, COUNT[3:0]}.
  function automatic logic [7:0] dut_status();
    return {bus.DATA_VALID, bus.FULL, bus.ALMOST_FULL, bus.OVERFLOW, bus.COUNT};
  endfunction

  function automatic logic [7:0] model_status();
    int n;
    n = model_q.size();
    return {n != 0, n == DEPTH, n >= AF, model_ovf, 4'(n)};
  endfunction

  // One clock of stimulus; the reference queue is advanced after the edge.
  task automatic drive(input logic wr, input logic [DW-1:0] d, input logic tx, input logic clr,
                       output logic popped, output logic [DW-1:0] exp_word,
                       output logic [DW-1:0] seen_word);
    logic full_m;
    @(negedge clk);
    bus.WR_EN    = wr;
    bus.WR_DATA  = d;
    bus.TX_START = tx;
    bus.CLR_OVF  = clr;
    #1;
    seen_word = bus.P_DATA;
    full_m    = (model_q.size() == DEPTH);
    popped    = tx && (model_q.size() != 0);
    exp_word  = popped ? model_q[0] : '0;
    @(posedge clk);
    #1;
    if (popped) void'(model_q.pop_front());
    if (wr && (!full_m || popped)) model_q.push_back(d);
    if (wr && full_m && !popped) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.WR_EN = 1'b0; bus.WR_DATA = '0; bus.TX_START = 1'b0; bus.CLR_OVF = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    n_cmp++;
    if (dut_status() !== 8'h00) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", dut_status(), 8'h00);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic p; logic [DW-1:0] e, s;
    drive(1'b1, 8'hA5, 1'b0, 1'b0, p, e, s);
    n_cmp++;
    if (dut_status() !== 8'h81) begin
      n_fail++; $display("FAIL single_status: got %h expected %h", dut_status(), 8'h81);
    end
    n_cmp++;
    if (bus.P_DATA !== 8'hA5) begin
      n_fail++; $display("FAIL single_data: got %h expected %h", bus.P_DATA, 8'hA5);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
    n_cmp++;
    if (dut_status() !== 8'h00) begin
      n_fail++; $display("FAIL single_pop_status: got %h expected %h", dut_status(), 8'h00);
    end
  endtask

  task automatic test_fill_overflow();
    logic p; logic [DW-1:0] e, s;
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, p, e, s);
      n_cmp++;
      if (dut_status() !== model_status()) begin
        n_fail++; $display("FAIL fill_status[%0d]: got %h expected %h", i, dut_status(), model_status());
      end
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b0, p, e, s);
    n_cmp++;
    if (dut_status() !== 8'hF8) begin
      n_fail++; $display("FAIL overflow_status: got %h expected %h", dut_status(), 8'hF8);
    end
    // Overflow and clear in the same cycle: set must win.
    drive(1'b1, 8'hEE, 1'b0, 1'b1, p, e, s);
    n_cmp++;
    if (dut_status() !== model_status()) begin
      n_fail++; $display("FAIL ovf_set_wins: got %h expected %h", dut_status(), model_status());
    end
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
      n_cmp++;
      if (s !== 8'(i)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, s, 8'(i));
      end
      n_cmp++;
      if (dut_status() !== model_status()) begin
        n_fail++; $display("FAIL drain_status[%0d]: got %h expected %h", i, dut_status(), model_status());
      end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b1, p, e, s);
    n_cmp++;
    if (dut_status() !== 8'h00) begin
      n_fail++; $display("FAIL clr_ovf: got %h expected %h", dut_status(), 8'h00);
    end
  endtask

  task automatic test_full_write_pop();
    logic p; logic [DW-1:0] e, s, w;
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0, p, e, s);
    w = DW'($urandom_range(0, 255));
    drive(1'b1, w, 1'b1, 1'b0, p, e, s);
    n_cmp++;
    if (s !== e) begin
      n_fail++; $display("FAIL full_wp_head: got %h expected %h", s, e);
    end
    n_cmp++;
    if (dut_status() !== 8'hE8) begin
      n_fail++; $display("FAIL full_wp_status: got %h expected %h", dut_status(), 8'hE8);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
      n_cmp++;
      if (s !== e) begin
        n_fail++; $display("FAIL full_wp_order[%0d]: got %h expected %h", i, s, e);
      end
    end
    n_cmp++;
    if (s !== w) begin
      n_fail++; $display("FAIL full_wp_last: got %h expected %h", s, w);
    end
  endtask

  task automatic test_interleave();
    logic p; logic [DW-1:0] e, s;
    int wr_left, pops, cyc;
    logic wr, tx;
    wr_left = 20;
    pops = 0;
    cyc = 0;
    while ((wr_left > 0 || model_q.size() > 0) && cyc < 400) begin
      wr = (wr_left > 0) && ($urandom_range(0, 3) != 0);
      tx = ($urandom_range(0, 2) == 0) || (wr_left == 0);
      if (wr && model_q.size() == DEPTH && !tx) wr = 1'b0;
      drive(wr, DW'($urandom_range(0, 255)), tx, 1'b0, p, e, s);
      if (wr) wr_left--;
      if (p) begin
        pops++;
        n_cmp++;
        if (s !== e) begin
          n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", pops, s, e);
        end
      end
      n_cmp++;
      if (dut_status() !== model_status()) begin
        n_fail++; $display("FAIL wrap_status[%0d]: got %h expected %h", cyc, dut_status(), model_status());
      end
      cyc++;
    end
    n_cmp++;
    if (pops != 20) begin
      n_fail++; $display("FAIL wrap_pops: got %0d expected %0d (cycles %0d)", pops, 20, cyc);
    end
  endtask

  task automatic test_empty_pop();
    logic p; logic [DW-1:0] e, s;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
      n_cmp++;
      if (dut_status() !== 8'h00) begin
        n_fail++; $display("FAIL empty_pop[%0d]: got %h expected %h", i, dut_status(), 8'h00);
      end
    end
    drive(1'b1, 8'h5A, 1'b0, 1'b0, p, e, s);
    n_cmp++;
    if (bus.P_DATA !== 8'h5A || dut_status() !== 8'h81) begin
      n_fail++; $display("FAIL empty_then_write: got %h/%h expected 5a/81", bus.P_DATA, dut_status());
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
  endtask

  task automatic test_reset_mid_frame();
    logic p; logic [DW-1:0] e, s;
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, DW'($urandom_range(0, 255)), 1'b0, 1'b0, p, e, s);
    drive(1'b1, 8'h77, 1'b0, 1'b0, p, e, s);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 8'h00, 1'b1, 1'b0, p, e, s);
    n_cmp++;
    if (dut_status() !== 8'h95) begin
      n_fail++; $display("FAIL pre_reset: got %h expected %h", dut_status(), 8'h95);
    end
    #2;
    rst = 1'b0;
    bus.TX_START = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    n_cmp++;
    if (dut_status() !== 8'h00) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", dut_status(), 8'h00);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h3C, 1'b0, 1'b0, p, e, s);
    n_cmp++;
    if (bus.P_DATA !== 8'h3C || dut_status() !== 8'h81) begin
      n_fail++; $display("FAIL post_reset_write: got %h/%h expected 3c/81", bus.P_DATA, dut_status());
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_write_pop();
    test_interleave();
    test_empty_pop();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
